// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller_pkg
// Brief    : Shared pipeline constants, FSM state encoding and load-use helper
// Revision : 1.0 - initial release
// ============================================================================
package hazard_controller_pkg;

    localparam int c_MUL_CYCLES_DEFAULT = 3;
    localparam int c_DIV_CYCLES_DEFAULT = 32;
    localparam int c_CNT_W              = 6;
    localparam int c_REG_W              = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hc_state_e;

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    function automatic logic load_use_hit(
        input logic               mem_read,
        input logic [c_REG_W-1:0] rd,
        input logic [c_REG_W-1:0] rs1,
        input logic [c_REG_W-1:0] rs2,
        input logic               use_rs1,
        input logic               use_rs2
    );
        return mem_read && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter16
// Brief    : 16-bit event counter that sticks at all-ones instead of wrapping
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count_q;
    logic [15:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_inc && (r_count_q != 16'hFFFF)) begin
            w_count_d = r_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= 16'd0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Load-use / branch-flush / multi-cycle MDU stall control for a
//            5-stage pipeline, with saturating stall and flush statistics
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_CYCLES = c_MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES = c_DIV_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ID_EX_MemRead,
    input  logic [c_REG_W-1:0] ID_EX_rd,
    input  logic [c_REG_W-1:0] IF_ID_rs1,
    input  logic [c_REG_W-1:0] IF_ID_rs2,
    input  logic               IF_ID_use_rs1,
    input  logic               IF_ID_use_rs2,
    input  logic               branch_taken,
    input  logic               mdu_start,
    input  logic               mdu_is_div,
    output logic               PC_Write,
    output logic               IF_ID_Write,
    output logic               IF_ID_Flush,
    output logic               ID_EX_Flush,
    output logic               EX_Stall,
    output logic               mdu_busy,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
);

    // The start cycle is itself a stall cycle, so the wait phase covers N-2.
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 2);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 2);

    hc_state_e          r_state_q;
    hc_state_e          w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               w_load_use;

    assign w_load_use = load_use_hit(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1,
                                     IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2);

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_Stall    = 1'b0;
        mdu_busy    = 1'b0;
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;

        if (!rst) begin
            case (r_state_q)
                RUN: begin
                    if (mdu_start) begin
                        EX_Stall    = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        mdu_busy    = 1'b1;
                        IF_ID_Flush = branch_taken;
                        ID_EX_Flush = branch_taken;
                        w_cnt_d     = mdu_is_div ? c_DIV_LOAD : c_MUL_LOAD;
                        w_state_d   = MDU_WAIT;
                    end else if (branch_taken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (w_load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (r_cnt_q != '0) begin
                        EX_Stall    = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        mdu_busy    = 1'b1;
                        w_cnt_d     = r_cnt_q - 1'b1;
                    end else begin
                        w_state_d   = RUN;
                    end
                end
                default: begin
                    w_state_d = RUN;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RUN;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (~PC_Write),
        .o_count (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (IF_ID_Flush),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Self-checking bench: directed table, corner sequences and random
//            stimulus against a cycle-index based reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic [4:0]  rd, rs1, rs2;
    logic        use1, use2, br, ms, isdiv;

    logic        pc_w [2];
    logic        ifid_w [2];
    logic        ifid_f [2];
    logic        idex_f [2];
    logic        ex_st [2];
    logic        busy [2];
    logic [15:0] st_cnt [2];
    logic [15:0] fl_cnt [2];

    hazard_controller u_dut0 (
        .clk(clk), .rst(rst), .ID_EX_MemRead(mem_read), .ID_EX_rd(rd),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .branch_taken(br), .mdu_start(ms), .mdu_is_div(isdiv),
        .PC_Write(pc_w[0]), .IF_ID_Write(ifid_w[0]), .IF_ID_Flush(ifid_f[0]),
        .ID_EX_Flush(idex_f[0]), .EX_Stall(ex_st[0]), .mdu_busy(busy[0]),
        .stall_cnt(st_cnt[0]), .flush_cnt(fl_cnt[0])
    );

    hazard_controller #(.MUL_CYCLES(2), .DIV_CYCLES(5)) u_dut1 (
        .clk(clk), .rst(rst), .ID_EX_MemRead(mem_read), .ID_EX_rd(rd),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .branch_taken(br), .mdu_start(ms), .mdu_is_div(isdiv),
        .PC_Write(pc_w[1]), .IF_ID_Write(ifid_w[1]), .IF_ID_Flush(ifid_f[1]),
        .ID_EX_Flush(idex_f[1]), .EX_Stall(ex_st[1]), .mdu_busy(busy[1]),
        .stall_cnt(st_cnt[1]), .flush_cnt(fl_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: an operation started at cycle t0 of length N stalls cycles
    // t0..t0+N-2, releases at t0+N-1 and the pipeline is free again at t0+N.
    int t = 0;
    int op_end [2] = '{0, 0};
    int mul_n  [2] = '{3, 2};
    int div_n  [2] = '{32, 5};
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    logic [5:0] smp [2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Output bits: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Stall, mdu_busy}
    function automatic logic [5:0] model_out(input int k);
        logic lu;
        lu = mem_read && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        if (rst) return 6'b110000;
        if (t < op_end[k]) return (t < op_end[k] - 1) ? 6'b000011 : 6'b110000;
        if (ms) return {2'b00, br, br, 2'b11};
        if (br) return 6'b111100;
        if (lu) return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic model_step(input int k, input logic [5:0] e);
        if (rst) begin
            op_end[k]  = 0;
            m_stall[k] = 0;
            m_flush[k] = 0;
        end else begin
            if (!(t < op_end[k]) && ms) op_end[k] = t + (isdiv ? div_n[k] : mul_n[k]);
            if (!e[5] && m_stall[k] < 65535) m_stall[k]++;
            if (e[3] && m_flush[k] < 65535) m_flush[k]++;
        end
    endtask

    task automatic do_cycle();
        logic [5:0] e;
        #1;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            smp[k] = {pc_w[k], ifid_w[k], ifid_f[k], idex_f[k], ex_st[k], busy[k]};
            chk($sformatf("outputs[dut%0d]", k), 16'(smp[k]), 16'(e));
            chk($sformatf("stall_cnt[dut%0d]", k), st_cnt[k], 16'(m_stall[k]));
            chk($sformatf("flush_cnt[dut%0d]", k), fl_cnt[k], 16'(m_flush[k]));
            model_step(k, e);
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle();
        {mem_read, rd, rs1, rs2, use1, use2, br, ms, isdiv} = '0;
    endtask

    task automatic reset_cycle();
        idle();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   n_st, rel_idx;
    logic [15:0] st0;

    initial begin
        vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, 6'b000100};
        vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 6'b110000};
        vecs[2] = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b1, 1'b1, 6'b111100};
        vecs[3] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 6'b110000};
        vecs[4] = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 6'b110000};
        vecs[5] = '{1'b1, 5'd31, 5'd31, 5'd2,  1'b1, 1'b0, 1'b0, 6'b000100};
        vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 6'b111100};
        vecs[7] = '{1'b1, 5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 6'b000100};

        idle();
        rst = 1'b1;
        @(negedge clk);
        do_cycle();
        do_cycle();
        rst = 1'b0;

        // Single-cycle RUN-state vectors
        for (int i = 0; i < 8; i++) begin
            {mem_read, rd, rs1, rs2, use1, use2, br} =
                {vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].br};
            st0 = st_cnt[0];
            do_cycle();
            chk($sformatf("table[%0d]", i), 16'(smp[0]), 16'(vecs[i].exp));
            idle();
            do_cycle();
            chk($sformatf("table_cnt[%0d]", i), st_cnt[0] - st0, vecs[i].exp[5] ? 16'd0 : 16'd1);
        end

        // Divide held for the whole stall on the default instance
        reset_cycle();
        ms = 1'b1; isdiv = 1'b1;
        n_st = 0; rel_idx = -1;
        for (int i = 0; i < 32; i++) begin
            do_cycle();
            if (smp[0][1]) n_st++;
            else if (rel_idx < 0) rel_idx = i;
        end
        idle();
        chk("div_stall_cycles", 16'(n_st), 16'd31);
        chk("div_release_idx", 16'(rel_idx), 16'd31);
        chk("div_stall_cnt", st_cnt[0], 16'd31);
        do_cycle();

        // Two-cycle multiply on the MUL_CYCLES=2 instance
        reset_cycle();
        ms = 1'b1; isdiv = 1'b0;
        do_cycle();
        chk("mul2_start_stall", 16'(smp[1][1:0]), 16'h3);
        do_cycle();
        chk("mul2_release", 16'(smp[1]), 16'h30);
        idle();
        do_cycle();
        chk("mul2_after", 16'(smp[1]), 16'h30);
        chk("mul2_stall_cnt", st_cnt[1], 16'd1);

        // Reset in the 10th cycle of a divide
        reset_cycle();
        ms = 1'b1; isdiv = 1'b1;
        for (int i = 0; i < 9; i++) do_cycle();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0; ms = 1'b0;
        do_cycle();
        chk("rst_abort_busy", 16'(smp[0][0]), 16'd0);
        chk("rst_abort_stall_cnt", st_cnt[0], 16'd0);
        chk("rst_abort_flush_cnt", fl_cnt[0], 16'd0);

        // Flush counter saturation
        reset_cycle();
        br = 1'b1;
        for (int i = 0; i < 65540; i++) do_cycle();
        chk("flush_sat", fl_cnt[0], 16'hFFFF);
        do_cycle();
        chk("flush_sat_hold", fl_cnt[0], 16'hFFFF);
        idle();

        // Random stimulus
        reset_cycle();
        for (int i = 0; i < 3000; i++) begin
            mem_read = 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 3));
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            use1  = 1'($urandom_range(0, 1));
            use2  = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 5) == 0);
            ms    = ($urandom_range(0, 11) == 0);
            isdiv = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 199) == 0);
            do_cycle();
        end
        rst = 1'b0;
        idle();
        do_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
